// File: rtl/control_param_encoder.sv
// Readback encoder: snapshots the large/small control registers and streams
// them out as coded 32-bit words {code, payload} over a valid/ready handshake.
module control_param_encoder #(
   parameter int N_LARGE   = 2,
   parameter int LARGE_W   = 32,
   parameter int N_SMALL   = 4,
   parameter int SMALL_W   = 16,
   parameter int PAYLOAD_W = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [N_LARGE*LARGE_W-1:0] large_registers,
   input  logic [N_SMALL*SMALL_W-1:0] small_registers,
   input  logic                       readback_all,
   input  logic                       readback_single,
   input  logic [7:0]                 readback_code,
   input  logic                       tx_ready,
   output logic [31:0]                tx_data,
   output logic                       tx_valid,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam int         NCODES   = 2*N_LARGE + N_SMALL;
   localparam logic [7:0] MAX_CODE = 8'(NCODES);

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   state_t                     state_q;
   logic [7:0]                 code_q;
   logic [7:0]                 last_q;
   logic [N_LARGE*LARGE_W-1:0] snap_large_q;
   logic [N_SMALL*SMALL_W-1:0] snap_small_q;
   logic [31:0]                tx_data_q;
   logic                       tx_valid_q;
   logic                       busy_q;
   logic                       done_q;
   logic                       err_q;

   logic [31:0] word_tbl [NCODES+1];
   logic [31:0] cur_word_d;
   logic [31:0] nxt_word_d;
   logic        single_ok_d;

   // Every code's word is formatted from the snapshot, so mid-dump register
   // changes never leak into the stream.
   assign word_tbl[0] = '0;

   generate
      for (genvar gi = 0; gi < N_LARGE; gi++) begin : g_large
         assign word_tbl[2*gi+1] = {8'(2*gi+1),
            24'(snap_large_q[gi*LARGE_W+PAYLOAD_W +: LARGE_W-PAYLOAD_W])};
         assign word_tbl[2*gi+2] = {8'(2*gi+2),
            24'(snap_large_q[gi*LARGE_W +: PAYLOAD_W])};
      end
      for (genvar gi = 0; gi < N_SMALL; gi++) begin : g_small
         assign word_tbl[2*N_LARGE+1+gi] = {8'(2*N_LARGE+1+gi),
            24'(snap_small_q[gi*SMALL_W +: SMALL_W])};
      end
   endgenerate

   always_comb begin
      cur_word_d = '0;
      nxt_word_d = '0;
      for (int k = 1; k <= NCODES; k++) begin
         if (code_q == 8'(k))   cur_word_d = word_tbl[k];
         if (code_q == 8'(k-1)) nxt_word_d = word_tbl[k];
      end
   end

   assign single_ok_d = (readback_code != 8'd0) && (readback_code <= MAX_CODE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         code_q       <= '0;
         last_q       <= '0;
         snap_large_q <= '0;
         snap_small_q <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (readback_all || (readback_single && single_ok_d)) begin
                  snap_large_q <= large_registers;
                  snap_small_q <= small_registers;
                  busy_q       <= 1'b1;
                  state_q      <= LOAD;
                  if (readback_all) begin
                     code_q <= 8'd1;
                     last_q <= MAX_CODE;
                  end else begin
                     code_q <= readback_code;
                     last_q <= readback_code;
                  end
               end else if (readback_single) begin
                  err_q <= 1'b1;
               end
            end
            LOAD: begin
               tx_data_q  <= cur_word_d;
               tx_valid_q <= 1'b1;
               state_q    <= SEND;
            end
            SEND: begin
               if (tx_ready) begin
                  if (code_q == last_q) begin
                     tx_valid_q <= 1'b0;
                     done_q     <= 1'b1;
                     busy_q     <= 1'b0;
                     state_q    <= IDLE;
                  end else begin
                     code_q    <= code_q + 8'd1;
                     tx_data_q <= nxt_word_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_control_param_encoder.sv
// Directed bench for control_param_encoder: dumps, backpressure, snapshot,
// single/invalid codes, busy ignore and asynchronous reset.
module tb_control_param_encoder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] large_registers;
   logic [63:0] small_registers;
   logic        readback_all;
   logic        readback_single;
   logic [7:0]  readback_code;
   logic        tx_ready;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        busy;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   control_param_encoder dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .large_registers (large_registers),
      .small_registers (small_registers),
      .readback_all    (readback_all),
      .readback_single (readback_single),
      .readback_code   (readback_code),
      .tx_ready        (tx_ready),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .busy            (busy),
      .done            (done),
      .err             (err)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] got[$];
   int done_cnt, err_cnt, first_idx, last_idx, hold_viol;

   logic [31:0] exp_full [8] = '{32'h01001234, 32'h02005678, 32'h0300DEAD, 32'h0400BEEF,
                                 32'h05001111, 32'h06002222, 32'h07003333, 32'h08004444};

   task automatic set_regs();
      large_registers = {32'hDEADBEEF, 32'h12345678};
      small_registers = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
   endtask

   // Raise request lines at a falling edge; collect() drops them one cycle later.
   task automatic issue(input logic all, input logic single, input logic [7:0] code);
      @(negedge clk);
      readback_all    = all;
      readback_single = single;
      readback_code   = code;
   endtask

   // mode 0: ready high, 1: ready 1,0,0 repeating, other: ready low.
   task automatic collect(input int mode, input int max_cyc, input int inj_cyc, input int snap_cyc);
      logic        pv, pr;
      logic [31:0] pd;
      int          after;
      got.delete();
      done_cnt = 0; err_cnt = 0; first_idx = -1; last_idx = -1; hold_viol = 0;
      pv = 1'b0; pr = 1'b0; pd = '0; after = -1;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (pv && !pr && (tx_valid !== 1'b1 || tx_data !== pd)) hold_viol++;
         if (done === 1'b1) begin
            done_cnt++;
            if (after < 0) after = c;
         end
         if (err === 1'b1) err_cnt++;
         if (c == 0) begin
            readback_all    = 1'b0;
            readback_single = 1'b0;
         end
         if (c == inj_cyc) begin
            readback_single = 1'b1;
            readback_code   = 8'd9;
         end else if (c == inj_cyc + 1) begin
            readback_single = 1'b0;
         end
         if (c == snap_cyc) large_registers[31:0] = 32'hAAAAAAAA;
         case (mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (c % 3 == 0);
            default: tx_ready = 1'b0;
         endcase
         if (tx_valid === 1'b1 && tx_ready) begin
            got.push_back(tx_data);
            if (first_idx < 0) first_idx = c;
            last_idx = c;
         end
         pv = tx_valid; pr = tx_ready; pd = tx_data;
         if (after >= 0 && c >= after + 2) break;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      readback_all = 1'b0; readback_single = 1'b0; readback_code = 8'd0; tx_ready = 1'b0;
      set_regs();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({tx_valid, busy, done, err} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags: got v/b/d/e=%b expected 0000", {tx_valid, busy, done, err});
      end
      tests_run++;
      if (tx_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_data: got %h expected 00000000", tx_data);
      end
      $display("[TB] reset: tx_valid=%b busy=%b tx_data=%h", tx_valid, busy, tx_data);
   endtask

   task automatic test_full_dump();
      set_regs();
      issue(1'b1, 1'b0, 8'd0);
      collect(0, 20, -10, -10);
      tests_run++;
      if (got.size() != 8) begin
         tests_failed++;
         $display("FAIL full_count: got %0d words expected 8", got.size());
      end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         tests_run++;
         if (got[i] !== exp_full[i]) begin
            tests_failed++;
            $display("FAIL full_word%0d: got %h expected %h", i, got[i], exp_full[i]);
         end
      end
      tests_run++;
      if (first_idx != 1 || last_idx != 8) begin
         tests_failed++;
         $display("FAIL full_timing: got first=%0d last=%0d expected 1 and 8", first_idx, last_idx);
      end
      tests_run++;
      if (done_cnt != 1) begin
         tests_failed++;
         $display("FAIL full_done: got %0d pulses expected 1", done_cnt);
      end
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_busy_after: got %b expected 0", busy);
      end
      $display("[TB] full dump: %0d words, done pulses %0d", got.size(), done_cnt);
   endtask

   task automatic test_backpressure();
      set_regs();
      issue(1'b1, 1'b0, 8'd0);
      collect(1, 60, -10, -10);
      tests_run++;
      if (got.size() != 8) begin
         tests_failed++;
         $display("FAIL bp_count: got %0d words expected 8", got.size());
      end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         tests_run++;
         if (got[i] !== exp_full[i]) begin
            tests_failed++;
            $display("FAIL bp_word%0d: got %h expected %h", i, got[i], exp_full[i]);
         end
      end
      tests_run++;
      if (hold_viol != 0) begin
         tests_failed++;
         $display("FAIL bp_hold: got %0d unstable stalls expected 0", hold_viol);
      end
      tests_run++;
      if (done_cnt != 1) begin
         tests_failed++;
         $display("FAIL bp_done: got %0d pulses expected 1", done_cnt);
      end
      $display("[TB] backpressure: %0d words, %0d hold violations", got.size(), hold_viol);
   endtask

   task automatic test_snapshot();
      set_regs();
      issue(1'b1, 1'b0, 8'd0);
      collect(0, 20, -10, 0);
      tests_run++;
      if (got.size() < 2 || got[0] !== 32'h01001234 || got[1] !== 32'h02005678) begin
         tests_failed++;
         $display("FAIL snap_first: got %h %h expected 01001234 02005678",
                  got.size() > 0 ? got[0] : 32'hx, got.size() > 1 ? got[1] : 32'hx);
      end
      issue(1'b1, 1'b0, 8'd0);
      collect(0, 20, -10, -10);
      tests_run++;
      if (got.size() < 2 || got[0] !== 32'h0100AAAA || got[1] !== 32'h0200AAAA) begin
         tests_failed++;
         $display("FAIL snap_second: got %h %h expected 0100aaaa 0200aaaa",
                  got.size() > 0 ? got[0] : 32'hx, got.size() > 1 ? got[1] : 32'hx);
      end
      $display("[TB] snapshot: second dump first word %h", got.size() > 0 ? got[0] : 32'hx);
      set_regs();
   endtask

   task automatic test_single();
      set_regs();
      issue(1'b0, 1'b1, 8'd6);
      collect(0, 20, -10, -10);
      tests_run++;
      if (got.size() != 1 || got[0] !== 32'h06002222) begin
         tests_failed++;
         $display("FAIL single6: got %0d words first %h expected 1 word 06002222",
                  got.size(), got.size() > 0 ? got[0] : 32'hx);
      end
      tests_run++;
      if (done_cnt != 1 || err_cnt != 0) begin
         tests_failed++;
         $display("FAIL single6_flags: got done=%0d err=%0d expected 1 and 0", done_cnt, err_cnt);
      end
      $display("[TB] single code 6: %0d word(s)", got.size());

      issue(1'b0, 1'b1, 8'd0);
      collect(0, 8, -10, -10);
      tests_run++;
      if (err_cnt != 1 || got.size() != 0 || done_cnt != 0) begin
         tests_failed++;
         $display("FAIL single0: got err=%0d words=%0d done=%0d expected 1 0 0", err_cnt, got.size(), done_cnt);
      end
      $display("[TB] single code 0: err pulses %0d", err_cnt);

      issue(1'b0, 1'b1, 8'd9);
      collect(0, 8, -10, -10);
      tests_run++;
      if (err_cnt != 1 || got.size() != 0 || done_cnt != 0) begin
         tests_failed++;
         $display("FAIL single9: got err=%0d words=%0d done=%0d expected 1 0 0", err_cnt, got.size(), done_cnt);
      end
      $display("[TB] single code 9: err pulses %0d", err_cnt);

      issue(1'b1, 1'b1, 8'd0);
      collect(0, 20, -10, -10);
      tests_run++;
      if (got.size() != 8 || err_cnt != 0) begin
         tests_failed++;
         $display("FAIL both_req: got words=%0d err=%0d expected 8 and 0", got.size(), err_cnt);
      end
      $display("[TB] both requests: %0d words, err pulses %0d", got.size(), err_cnt);
   endtask

   task automatic test_busy_ignore();
      set_regs();
      issue(1'b1, 1'b0, 8'd0);
      collect(0, 20, 3, -10);
      tests_run++;
      if (got.size() != 8 || err_cnt != 0 || done_cnt != 1) begin
         tests_failed++;
         $display("FAIL busy_ignore: got words=%0d err=%0d done=%0d expected 8 0 1",
                  got.size(), err_cnt, done_cnt);
      end
      $display("[TB] busy ignore: %0d words, err pulses %0d", got.size(), err_cnt);
   endtask

   task automatic test_reset_mid();
      int stray;
      set_regs();
      issue(1'b1, 1'b0, 8'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 0) readback_all = 1'b0;
         tx_ready = (c == 1 || c == 2);
      end
      tests_run++;
      if (tx_valid !== 1'b1 || tx_data !== 32'h0300DEAD) begin
         tests_failed++;
         $display("FAIL rst_pre: got valid=%b data=%h expected 1 0300dead", tx_valid, tx_data);
      end
      #2 reset_n = 1'b0;
      #1;
      tests_run++;
      if ({tx_valid, busy, done, err} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL rst_async: got v/b/d/e=%b expected 0000", {tx_valid, busy, done, err});
      end
      #1 reset_n = 1'b1;
      tx_ready = 1'b1;
      stray = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (tx_valid !== 1'b0 || busy !== 1'b0) stray++;
      end
      tests_run++;
      if (stray != 0) begin
         tests_failed++;
         $display("FAIL rst_after: got %0d active cycles expected 0", stray);
      end
      $display("[TB] mid-dump reset: post-release active cycles %0d", stray);
   endtask

   initial begin
      test_reset();
      test_full_dump();
      test_backpressure();
      test_snapshot();
      test_single();
      test_busy_ignore();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
